// File: rtl/multicycle_sequencer.sv
// Execute-stage sequencer for multi-cycle multiply/divide ops with flush drain.
// Optional watchdog abort on WAIT/DRAIN timeout: define EXEC_WATCHDOG_EN.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [1:0] op_kind,
  input  logic       flush,
  input  logic       mult_done,
  input  logic       div_done,
  output logic       mult_start,
  output logic       div_start,
  output logic       stall,
  output logic [1:0] result_sel,
  output logic       result_valid,
  output logic       busy,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_COMPLETE,
    S_DRAIN
  } state_t;

  localparam logic [1:0] K_MUL = 2'b01;
  localparam logic [1:0] K_DIV = 2'b10;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_chk
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_kind;
  logic       w_multi;
  logic       w_accept;
  logic       w_done;

  assign w_multi  = op_valid && (op_kind == K_MUL || op_kind == K_DIV);
  assign w_accept = (r_state == S_IDLE) && w_multi && !flush;
  assign w_done   = (r_kind == K_MUL && mult_done) ||
                    (r_kind == K_DIV && div_done);

`ifdef EXEC_WATCHDOG_EN
  logic [7:0] r_cnt;
  logic       r_error;
  logic       w_timeout;
  logic       w_abort;
  logic       w_wd_state;
  logic       w_wd_enter;

  assign w_wd_state = (r_state == S_WAIT) || (r_state == S_DRAIN);
  assign w_wd_enter = (w_next == S_WAIT || w_next == S_DRAIN) &&
                      (w_next != r_state);
  assign w_timeout  = w_wd_state &&
                      (r_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 8'd0;
      r_error <= 1'b0;
    end else begin
      if (w_wd_enter)
        r_cnt <= 8'd0;
      else if (w_wd_state)
        r_cnt <= r_cnt + 8'd1;
      if (w_abort)
        r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_kind  <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_kind <= op_kind;
    end
  end

  always_comb begin
    w_next       = r_state;
    stall        = 1'b0;
    mult_start   = 1'b0;
    div_start    = 1'b0;
    result_valid = 1'b0;
    result_sel   = r_kind;
    busy         = (r_state != S_IDLE);
`ifdef EXEC_WATCHDOG_EN
    w_abort      = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          stall  = 1'b1;
          w_next = S_START;
        end else if (op_valid && !w_multi) begin
          result_sel = op_kind;
        end
      end
      S_START: begin
        stall      = 1'b1;
        mult_start = (r_kind == K_MUL);
        div_start  = (r_kind == K_DIV);
        w_next     = flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        // Done alongside flush: unit already finished, nothing to drain.
        if (w_done)
          w_next = flush ? S_IDLE : S_COMPLETE;
        else if (flush)
          w_next = S_DRAIN;
`ifdef EXEC_WATCHDOG_EN
        else if (w_timeout) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end
`endif
      end
      S_COMPLETE: begin
        result_valid = 1'b1;
        w_next       = S_IDLE;
      end
      S_DRAIN: begin
        stall = w_multi;
        if (w_done)
          w_next = S_IDLE;
`ifdef EXEC_WATCHDOG_EN
        else if (w_timeout) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: ALU/FPU pass-through, mul/div,
// flush drain, reset abandon and watchdog (EXEC_WATCHDOG_EN) behaviour.
module tb_multicycle_sequencer;

`ifdef EXEC_WATCHDOG_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 128;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       op_valid = 1'b0;
  logic [1:0] op_kind = 2'b00;
  logic       flush = 1'b0;
  logic       mult_done = 1'b0;
  logic       div_done = 1'b0;
  logic       mult_start;
  logic       div_start;
  logic       stall;
  logic [1:0] result_sel;
  logic       result_valid;
  logic       busy;
  logic       error;

  int checks = 0;
  int failures = 0;

  multicycle_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .op_valid(op_valid),
    .op_kind(op_kind),
    .flush(flush),
    .mult_done(mult_done),
    .div_done(div_done),
    .mult_start(mult_start),
    .div_start(div_start),
    .stall(stall),
    .result_sel(result_sel),
    .result_valid(result_valid),
    .busy(busy),
    .error(error)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs at the falling edge, let outputs settle.
  task automatic cyc(input logic v, input logic [1:0] k, input logic f,
                     input logic md, input logic dd);
    @(negedge clk);
    op_valid  = v;
    op_kind   = k;
    flush     = f;
    mult_done = md;
    div_done  = dd;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({busy, stall, error, mult_start, div_start, result_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=000000",
               {busy, stall, error, mult_start, div_start, result_valid});
    end
    checks++;
    if (result_sel !== 2'b00) begin
      failures++;
      $display("FAIL reset_sel got=%b want=00", result_sel);
    end
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 2'b00, 0, 0, 0);
  endtask

  task automatic test_alu_fpu();
    cyc(1, 2'b00, 0, 0, 0);
    checks++;
    if ({stall, busy, mult_start, div_start, result_sel} !== 6'b000000) begin
      failures++;
      $display("FAIL alu got=%b want=000000",
               {stall, busy, mult_start, div_start, result_sel});
    end
    cyc(1, 2'b11, 0, 0, 0);
    checks++;
    if ({stall, busy, mult_start, div_start, result_sel} !== 6'b000011) begin
      failures++;
      $display("FAIL fpu got=%b want=000011",
               {stall, busy, mult_start, div_start, result_sel});
    end
    cyc(0, 2'b00, 0, 0, 0);
  endtask

  task automatic test_multiply();
    cyc(1, 2'b01, 0, 0, 0);
    checks++;
    if ({stall, busy, mult_start} !== 3'b100) begin
      failures++;
      $display("FAIL mul_accept got=%b want=100", {stall, busy, mult_start});
    end
    for (int c = 1; c <= 7; c++) begin
      logic [5:0] exp_v;
      cyc(0, 2'b00, 0, c == 5, 0);
      exp_v = {c == 1, 1'b0, c <= 5, c == 6, c <= 6, 1'b0};
      checks++;
      if ({mult_start, div_start, stall, result_valid, busy, error} !== exp_v
          || result_sel !== 2'b01) begin
        failures++;
        $display("FAIL mul_c%0d got=%b sel=%b want=%b sel=01", c,
                 {mult_start, div_start, stall, result_valid, busy, error},
                 result_sel, exp_v);
      end
    end
  endtask

  task automatic test_divide_stray();
    cyc(1, 2'b10, 0, 0, 0);
    for (int c = 1; c <= 6; c++) begin
      logic [4:0] exp_v;
      cyc(0, 2'b00, 0, c == 2, c == 1 || c == 4);
      exp_v = {1'b0, c == 1, c <= 4, c == 5, c <= 5};
      checks++;
      if ({mult_start, div_start, stall, result_valid, busy} !== exp_v
          || result_sel !== 2'b10) begin
        failures++;
        $display("FAIL div_c%0d got=%b sel=%b want=%b sel=10", c,
                 {mult_start, div_start, stall, result_valid, busy},
                 result_sel, exp_v);
      end
    end
  endtask

  task automatic test_flush_drain();
    int rv_seen = 0;
    cyc(1, 2'b10, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0);
    cyc(0, 2'b00, 1, 0, 0);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL drain_c2_stall got=%b want=1", stall);
    end
    for (int c = 3; c <= 6; c++) begin
      cyc(1, 2'b01, 0, 0, c == 6);
      if (result_valid) rv_seen++;
      checks++;
      if ({stall, busy, mult_start, div_start} !== 4'b1100) begin
        failures++;
        $display("FAIL drain_c%0d got=%b want=1100", c,
                 {stall, busy, mult_start, div_start});
      end
    end
    cyc(1, 2'b01, 0, 0, 0);
    if (result_valid) rv_seen++;
    checks++;
    if ({stall, busy} !== 2'b10) begin
      failures++;
      $display("FAIL drain_c7 got=%b want=10", {stall, busy});
    end
    cyc(0, 2'b00, 0, 0, 0);
    checks++;
    if ({mult_start, div_start, result_sel} !== 4'b1001) begin
      failures++;
      $display("FAIL drain_c8_start got=%b want=1001",
               {mult_start, div_start, result_sel});
    end
    checks++;
    if (rv_seen != 0) begin
      failures++;
      $display("FAIL drain_no_result got=%0d want=0", rv_seen);
    end
    cyc(0, 2'b00, 0, 1, 0);
    cyc(0, 2'b00, 0, 0, 0);
    checks++;
    if (result_valid !== 1'b1) begin
      failures++;
      $display("FAIL drain_next_result got=%b want=1", result_valid);
    end
    cyc(0, 2'b00, 0, 0, 0);
  endtask

  task automatic test_flush_start();
    cyc(1, 2'b01, 0, 0, 0);
    cyc(0, 2'b00, 1, 0, 0);
    checks++;
    if ({mult_start, stall} !== 2'b11) begin
      failures++;
      $display("FAIL fstart_pulse got=%b want=11", {mult_start, stall});
    end
    cyc(0, 2'b00, 0, 0, 0);
    checks++;
    if ({busy, stall, mult_start} !== 3'b100) begin
      failures++;
      $display("FAIL fstart_drain got=%b want=100", {busy, stall, mult_start});
    end
    cyc(0, 2'b00, 0, 1, 0);
    cyc(0, 2'b00, 0, 0, 0);
    checks++;
    if ({busy, result_valid} !== 2'b00) begin
      failures++;
      $display("FAIL fstart_idle got=%b want=00", {busy, result_valid});
    end
  endtask

  task automatic test_flush_idle();
    cyc(1, 2'b10, 1, 0, 0);
    checks++;
    if ({stall, busy} !== 2'b00) begin
      failures++;
      $display("FAIL fidle_accept got=%b want=00", {stall, busy});
    end
    cyc(0, 2'b00, 0, 0, 0);
    checks++;
    if ({busy, mult_start, div_start} !== 3'b000) begin
      failures++;
      $display("FAIL fidle_next got=%b want=000", {busy, mult_start, div_start});
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    cyc(1, 2'b01, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, stall, mult_start, result_valid, error, result_sel} !== 7'b0) begin
      failures++;
      $display("FAIL rstmid_async got=%b want=0000000",
               {busy, stall, mult_start, result_valid, error, result_sel});
    end
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 2'b00, 0, 1, 0);
    for (int c = 0; c < 4; c++) begin
      cyc(0, 2'b00, 0, 0, 0);
      if (result_valid || busy || mult_start || error) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rstmid_after got=%0d bad cycles want=0", bad);
    end
  endtask

  task automatic test_watchdog();
`ifdef EXEC_WATCHDOG_EN
    cyc(1, 2'b01, 0, 0, 0);
    for (int c = 1; c <= 9; c++) begin
      logic [3:0] exp_v;
      cyc(0, 2'b00, 0, 0, 0);
      exp_v = {c <= 5, c <= 5, c >= 6, 1'b0};
      checks++;
      if ({stall, busy, error, result_valid} !== exp_v) begin
        failures++;
        $display("FAIL wd_c%0d got=%b want=%b", c,
                 {stall, busy, error, result_valid}, exp_v);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (error !== 1'b0) begin
      failures++;
      $display("FAIL wd_reset_clear got=%b want=0", error);
    end
    @(negedge clk);
    reset = 1'b0;
`else
    int bad = 0;
    cyc(1, 2'b01, 0, 0, 0);
    for (int c = 1; c <= 300; c++) begin
      cyc(0, 2'b00, 0, 0, 0);
      if (!stall || error || !busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL nowd_hold got=%0d bad cycles want=0", bad);
    end
    cyc(0, 2'b00, 0, 1, 0);
    cyc(0, 2'b00, 0, 0, 0);
    checks++;
    if ({result_valid, error} !== 2'b10) begin
      failures++;
      $display("FAIL nowd_finish got=%b want=10", {result_valid, error});
    end
`endif
    cyc(0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_alu_fpu();
    test_multiply();
    test_divide_stray();
    test_flush_drain();
    test_flush_start();
    test_flush_idle();
    test_reset_mid();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 128, WAIT/DRAIN cycles before watchdog abort; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op_valid  input  1  decoded execute op present this cycle.
REQ-005 op_kind  input  2  00 ALU, 01 multiplier, 10 divider, 11 FPU.
REQ-006 flush  input  1  discard in-flight multi-cycle op.
REQ-007 mult_done  input  1  multiplier completion pulse.
REQ-008 div_done  input  1  divider completion pulse.
REQ-009 mult_start  output  1  one-cycle multiplier start pulse.
REQ-010 div_start  output  1  one-cycle divider start pulse.
REQ-011 stall  output  1  hold fetch/decode; stage not complete.
REQ-012 result_sel  output  2  execute result mux select; same encoding as op_kind.
REQ-013 result_valid  output  1  one-cycle pulse, multi-cycle result ready.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 error  output  1  sticky watchdog abort flag.

Function
REQ-016 FSM states: IDLE, START, WAIT, COMPLETE, DRAIN; one state register, one-hot or binary.
REQ-017 IDLE: op_valid with op_kind 00/11 -> stay IDLE; stall=0; result_sel=op_kind combinationally.
REQ-018 IDLE: op_valid with op_kind 01/10 and flush=0 -> accept; kind latched into kind_q; stall=1 same cycle; next state START.
REQ-019 START: exactly one of mult_start/div_start=1 per kind_q for this single cycle; stall=1; next state WAIT.
REQ-020 WAIT: stall=1; done of kind_q's unit -> COMPLETE; the other unit's done ignored.
REQ-021 Done pulses arriving in START are ignored.
REQ-022 COMPLETE: stall=0, result_valid=1, result_sel=kind_q; next state IDLE; no new op accepted this cycle.
REQ-023 Outside COMPLETE and IDLE-ALU/FPU cases, result_sel=kind_q.
REQ-024 Minimum multi-cycle latency: accept cycle to result_valid = 3 cycles (done seen in first WAIT cycle).
REQ-025 flush in START or WAIT -> DRAIN next cycle; in START the start pulse is still issued.
REQ-026 DRAIN: stall=0 unless op_valid with multi-cycle kind (then stall=1, op not accepted); matching done -> IDLE, no result_valid.
REQ-027 flush in IDLE blocks acceptance that cycle; flush in COMPLETE or DRAIN has no effect.
REQ-028 mult_start and div_start never high simultaneously and never high outside START.
REQ-029 busy=1 in START, WAIT, COMPLETE, DRAIN.

Reset
REQ-030 reset asserted: state=IDLE, kind_q=00, watchdog count=0, error=0, all start/valid pulses 0, immediately (asynchronous).
REQ-031 Reset mid-operation abandons the op; no start, result_valid or error generated on release.

Configuration
REQ-032 Macro EXEC_WATCHDOG_EN.
REQ-033 Defined: 8-bit counter clears on entry to WAIT/DRAIN, increments each cycle there; reaching TIMEOUT_CYCLES -> IDLE, error=1 held until reset, no result_valid.
REQ-034 Undefined: no counter logic; error tied 0; WAIT/DRAIN wait indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-035 ALU op (op_kind=00) then FPU op on consecutive cycles -> stall=0, result_sel 00 then 11, no start pulses.
REQ-036 Multiply accepted cycle 0, mult_done cycle 5 -> mult_start cycle 1 only, stall cycles 0-5, result_valid cycle 6, result_sel=01, busy low cycle 7.
REQ-037 Divide with stray mult_done in WAIT, div_done cycle 4 -> only div_done ends op, result_valid cycle 5, result_sel=10.
REQ-038 Divide accepted, flush cycle 2, new multiply op_valid cycle 3, div_done cycle 6 -> DRAIN; stall=1 cycles 3-6; no result_valid; multiply accepted cycle 7.
REQ-039 EXEC_WATCHDOG_EN, TIMEOUT_CYCLES=4, multiply with no done -> abort to IDLE after 4 WAIT cycles, error=1 sticky; reset clears it; macro undefined -> stall held indefinitely, error=0.
REQ-040 Assert reset during WAIT -> outputs at reset values immediately; later mult_done produces no result_valid.
